dmx1_32_row_buf: RTL and testbench
==================================

// Module: dmx1_32_row_buf
// PURPOSE
//  Serial-to-parallel row collector: the write-side counterpart of the 32:1 coefficient read mux.
//  Accepts one signed 16-bit coefficient per handshake and scatters it into a 32-entry row register.
//  Presents the completed row (4/8/16/32 entries per TU size) in parallel to the next transform stage.
//  Sits between serial coefficient producers (dequant/scan) and the row-parallel 1-D DCT/IDCT stages.
// PARAMETERS
//  DW     16   coefficient width, signed two's complement
//  DEPTH  32   row entries; fixed, sizes 4/8/16/32 map onto entries 0..N-1
// PORTS
//  clk        in   1        clock; all logic on rising edge
//  rst_n      in   1        asynchronous reset, active-low
//  i_clr      in   1        synchronous flush: drop partial/held row
//  i_size     in   2        row length: 0=4, 1=8, 2=16, 3=32; sampled on first element of a row
//  i_val      in   1        input coefficient valid
//  i_dt       in   DW       input coefficient, signed
//  o_rdy      out  1        collector can accept i_dt this cycle
//  o_val      out  1        complete row held on o_row
//  o_row      out  DW*32    entry k at o_row[DW*k +: DW]; entries >= N read 0
//  o_size     out  2        size code of the row on o_row
//  i_rdy      in   1        downstream accepts o_row this cycle
// BEHAVIOUR
//  Reset (rst_n=0): o_val=0, o_row=0, o_size=0, write index wr_idx=0, state FILL; o_rdy=1 after release.
//  Input accept: acc = i_val & o_rdy. Output accept: dacc = o_val & i_rdy.
//  o_rdy = ~o_val | i_rdy (combinational); a held row is never overwritten before it is taken.
//  States:
//   FILL: on acc, entry[wr_idx] <= i_dt, wr_idx++. If wr_idx==0 on acc: latch size_r <= i_size,
//         clear entries 1..31 to 0 in the same cycle. When acc at wr_idx==N-1: wr_idx<=0, o_val<=1,
//         o_size<=size_r, go HOLD.
//   HOLD: o_row stable. If dacc: o_val<=0 -> FILL. If dacc & acc in the same cycle: row handed over
//         (downstream samples the current o_row) and i_dt is written as entry 0 of the next row,
//         with clear of 1..31 and size latch as above; no bubble, 1 coefficient/cycle sustained.
//  Latency: last coefficient accepted at edge T -> o_val=1 from T+1. Full row = N accepts minimum.
//  i_size changes mid-row are ignored until the next row start (wr_idx==0).
//  i_dt is latched unmodified; no sign extension or saturation (DW in = DW out).
//  i_clr: next edge wr_idx<=0, o_val<=0, FILL; o_row contents unchanged (masked by o_val=0).
//   i_clr has priority over acc/dacc in the same cycle; the coefficient presented that cycle is dropped.
//  rst_n asserted mid-row or mid-HOLD: immediate return to the reset state; the partial row is lost.
//  i_val=0 in FILL: wr_idx and entries hold; gaps in input are allowed.
//  No overflow possible: o_rdy=0 whenever a full row is held and not taken.
// TESTING
//  1 size=3, 32 back-to-back i_dt=k (k=0..31), i_rdy=1 -> o_val 1 cycle after 32nd accept, o_row entry k=k.
//  2 size=0, i_dt=-1,2,-3,4 -> o_row entries 0..3 = FFFF,0002,FFFD,0004, entries 4..31 = 0, o_size=0.
//  3 size=1 row held, i_rdy=0 for 5 cycles -> o_rdy=0, o_row stable; i_rdy=1 with i_val=1 -> next row
//    entry0 written that cycle, no lost or duplicated coefficient over 10 rows.
//  4 size=2, 7 accepts, then i_size=0, 9 more -> row completes at 16 entries, o_size=2.
//  5 i_clr after 5 of 8 accepts -> o_val stays 0; next 8 accepts form a clean row with wr_idx from 0.
//  6 rst_n low during HOLD -> o_val=0, o_row=0 immediately; random val/rdy vs. a scoreboard model.

Source files
------------

// File: rtl/dmx1_32_row_buf.sv
// Serial-to-parallel row collector: gathers signed coefficients one per handshake
// into a 32-entry row and presents the finished 4/8/16/32-entry row in parallel.
//
// state   | meaning
// ST_FILL | collecting coefficients into entries 0..N-1 (wr_idx = next slot)
// ST_HOLD | complete row on o_row with o_val=1, waiting for downstream accept
module dmx1_32_row_buf #(
  parameter int DW    = 16,
  parameter int DEPTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic [1:0]          i_size,
  input  logic                i_val,
  input  logic [DW-1:0]       i_dt,
  output logic                o_rdy,
  output logic                o_val,
  output logic [DW*DEPTH-1:0] o_row,
  output logic [1:0]          o_size,
  input  logic                i_rdy
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t         r_state;
  logic           r_val;
  logic [1:0]     r_size_cur;
  logic [1:0]     r_size_out;
  logic [IW-1:0]  r_wr_idx;
  logic [DW-1:0]  r_ent [DEPTH];

  logic           w_acc;
  logic           w_dacc;
  logic           w_row_start;
  logic [IW-1:0]  w_last_idx;

  always_comb begin
    w_last_idx = IW'(DEPTH - 1);
    case (r_size_cur)
      2'd0:    w_last_idx = IW'(3);
      2'd1:    w_last_idx = IW'(7);
      2'd2:    w_last_idx = IW'(15);
      default: w_last_idx = IW'(DEPTH - 1);
    endcase
  end

  // A held row can only be replaced in the same cycle it is taken.
  assign o_rdy       = (r_state != ST_HOLD) | i_rdy;
  assign w_acc       = i_val & o_rdy;
  assign w_dacc      = (r_state == ST_HOLD) & i_rdy;
  assign w_row_start = (r_wr_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FILL;
      r_val      <= 1'b0;
      r_size_cur <= 2'd0;
      r_size_out <= 2'd0;
      r_wr_idx   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_ent[k] <= '0;
      end
    end else if (i_clr) begin
      r_state  <= ST_FILL;
      r_val    <= 1'b0;
      r_wr_idx <= '0;
    end else begin
      if (w_dacc) begin
        r_val   <= 1'b0;
        r_state <= ST_FILL;
      end
      // In HOLD an accept always coincides with a take and wr_idx is 0,
      // so the next row starts here with no bubble.
      if (w_acc) begin
        if (w_row_start) begin
          r_size_cur <= i_size;
          r_ent[0]   <= i_dt;
          for (int k = 1; k < DEPTH; k++) begin
            r_ent[k] <= '0;
          end
          r_wr_idx <= IW'(1);
        end else begin
          r_ent[r_wr_idx] <= i_dt;
          if (r_wr_idx == w_last_idx) begin
            r_wr_idx   <= '0;
            r_val      <= 1'b1;
            r_size_out <= r_size_cur;
            r_state    <= ST_HOLD;
          end else begin
            r_wr_idx <= r_wr_idx + 1'b1;
          end
        end
      end
    end
  end

  // Entries beyond N are already zero because every row start clears 1..31.
  always_comb begin
    o_row = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_row[DW*k +: DW] = r_ent[k];
    end
  end

  assign o_val  = r_val;
  assign o_size = r_size_out;

endmodule

// File: tb/tb_dmx1_32_row_buf.sv
// Directed vector table plus scoreboard-checked sequences for dmx1_32_row_buf.
module tb_dmx1_32_row_buf;
  localparam int DW = 16;
  localparam int RW = DW * 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_clr = 1'b0;
  logic [1:0]    i_size = 2'd0;
  logic          i_val = 1'b0;
  logic [DW-1:0] i_dt = '0;
  logic          i_rdy = 1'b0;
  logic          o_rdy;
  logic          o_val;
  logic [RW-1:0] o_row;
  logic [1:0]    o_size;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmx1_32_row_buf #(.DW(DW), .DEPTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (i_clr),
    .i_size(i_size),
    .i_val (i_val),
    .i_dt  (i_dt),
    .o_rdy (o_rdy),
    .o_val (o_val),
    .o_row (o_row),
    .o_size(o_size),
    .i_rdy (i_rdy)
  );

  typedef struct {
    logic        clr;
    logic [1:0]  size;
    logic        val;
    logic [15:0] dt;
    logic        rdy;
    logic        e_rdy;
    logic        e_val;
    logic [1:0]  e_size;
    logic [63:0] e_lo;
    logic        chk_hi;
  } vec_t;

  typedef struct {
    logic [1:0]    size;
    logic [RW-1:0] row;
  } row_t;

  vec_t          tbl [21];
  row_t          sb_q [$];
  logic [1:0]    sb_size;
  int            sb_cnt;
  logic [RW-1:0] sb_row;
  logic          acc;
  logic [15:0]   seq;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    i_clr  = 1'b0;
    i_val  = 1'b0;
    i_rdy  = 1'b0;
    i_size = 2'd0;
    i_dt   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_reset();
    sb_q.delete();
    sb_cnt = 0;
    sb_size = 2'd0;
    sb_row = '0;
  endtask

  // Transaction scoreboard: rows are assembled from accepted coefficients,
  // size taken at each row start, and compared while held.
  task automatic sb_cycle(input logic v, input logic [15:0] d, input logic [1:0] s,
                          input logic r, output logic acc_o);
    logic ev, er, dacc;
    i_clr  = 1'b0;
    i_val  = v;
    i_dt   = d;
    i_size = s;
    i_rdy  = r;
    ev     = (sb_q.size() != 0);
    er     = !ev || r;
    acc_o  = v && er;
    dacc   = ev && r;
    #1;
    chk("sb_rdy", o_rdy, er);
    if (ev) begin
      chk("sb_row", o_row, sb_q[0].row);
      chk("sb_size", o_size, sb_q[0].size);
    end
    if (dacc) void'(sb_q.pop_front());
    if (acc_o) begin
      if (sb_cnt == 0) begin
        sb_size = s;
        sb_row  = '0;
      end
      sb_row[DW*sb_cnt +: DW] = d;
      sb_cnt++;
      if (sb_cnt == (4 << sb_size)) begin
        sb_q.push_back('{sb_size, sb_row});
        sb_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("sb_val", o_val, sb_q.size() != 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    //           clr  size  val  dt        rdy  e_rdy e_val e_size e_lo                    chk_hi
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0000_0000_0000_FFFF, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0000_0000_0002_FFFF, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 16'hFFFD, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0000_FFFD_0002_FFFF, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b1, 2'd0, 64'h0004_FFFD_0002_FFFF, 1'b1};
    tbl[4]  = '{1'b0, 2'd1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 2'd0, 64'h0004_FFFD_0002_FFFF, 1'b1};
    tbl[5]  = '{1'b0, 2'd1, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 2'd0, 64'h0000_0000_0000_1111, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0000_0000_0002_1111, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0000_0003_0002_1111, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0004_0003_0002_1111, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b1, 16'h0005, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0004_0003_0002_1111, 1'b0};
    tbl[10] = '{1'b1, 2'd1, 1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0, 2'd0, 64'h0004_0003_0002_1111, 1'b0};
    tbl[11] = '{1'b0, 2'd1, 1'b1, 16'h000A, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0000_0000_0000_000A, 1'b1};
    tbl[12] = '{1'b0, 2'd1, 1'b1, 16'h000B, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0000_0000_000B_000A, 1'b0};
    tbl[13] = '{1'b0, 2'd1, 1'b0, 16'h7777, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0000_0000_000B_000A, 1'b0};
    tbl[14] = '{1'b0, 2'd1, 1'b1, 16'h000C, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0000_000C_000B_000A, 1'b0};
    tbl[15] = '{1'b0, 2'd1, 1'b1, 16'h000D, 1'b0, 1'b1, 1'b0, 2'd0, 64'h000D_000C_000B_000A, 1'b0};
    tbl[16] = '{1'b0, 2'd1, 1'b1, 16'h000E, 1'b0, 1'b1, 1'b0, 2'd0, 64'h000D_000C_000B_000A, 1'b0};
    tbl[17] = '{1'b0, 2'd1, 1'b1, 16'h000F, 1'b0, 1'b1, 1'b0, 2'd0, 64'h000D_000C_000B_000A, 1'b0};
    tbl[18] = '{1'b0, 2'd1, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 2'd0, 64'h000D_000C_000B_000A, 1'b0};
    tbl[19] = '{1'b0, 2'd1, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 2'd1, 64'h000D_000C_000B_000A, 1'b0};
    tbl[20] = '{1'b0, 2'd1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd1, 64'h000D_000C_000B_000A, 1'b0};

    // Reset state
    do_reset();
    chk("rst_val", o_val, 1'b0);
    chk("rst_row", o_row, '0);
    chk("rst_size", o_size, 2'd0);
    chk("rst_rdy", o_rdy, 1'b1);

    // 32-entry row, back to back
    for (int k = 0; k < 32; k++) begin
      i_val = 1'b1; i_dt = 16'(k); i_size = 2'd3; i_rdy = 1'b1;
      @(posedge clk);
      #1;
      if (k == 30) chk("t1_val_early", o_val, 1'b0);
    end
    chk("t1_val", o_val, 1'b1);
    chk("t1_size", o_size, 2'd3);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("t1_ent%0d", k), o_row[DW*k +: DW], 16'(k));
    end
    i_val = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_taken", o_val, 1'b0);

    // Size-4 signed row, hold, handover into size-8 row, flush, clean row
    do_reset();
    for (int i = 0; i < 21; i++) begin
      i_clr = tbl[i].clr; i_size = tbl[i].size; i_val = tbl[i].val;
      i_dt = tbl[i].dt; i_rdy = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_rdy", i), o_rdy, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_val", i), o_val, tbl[i].e_val);
      chk($sformatf("v%0d_size", i), o_size, tbl[i].e_size);
      chk($sformatf("v%0d_lo", i), o_row[63:0], tbl[i].e_lo);
      if (tbl[i].chk_hi) chk($sformatf("v%0d_hi", i), o_row[RW-1:64], '0);
    end
    i_clr = 1'b0;

    // Size change mid-row is ignored
    do_reset();
    for (int k = 0; k < 16; k++) begin
      i_val = 1'b1; i_size = (k < 7) ? 2'd2 : 2'd0; i_dt = 16'h0100 + 16'(k); i_rdy = 1'b0;
      @(posedge clk);
      #1;
      if (k == 14) chk("t4_val_early", o_val, 1'b0);
    end
    chk("t4_val", o_val, 1'b1);
    chk("t4_size", o_size, 2'd2);
    chk("t4_ent0", o_row[15:0], 16'h0100);
    chk("t4_ent15", o_row[DW*15 +: DW], 16'h010F);
    chk("t4_hi", o_row[RW-1:DW*16], '0);
    i_val = 1'b0;

    // Held row under backpressure, then sustained streaming of 10+ rows
    do_reset();
    sb_reset();
    seq = 16'h0000;
    for (int c = 0; c < 8; c++) begin
      sb_cycle(1'b1, seq, 2'd1, 1'b0, acc);
      if (acc) seq++;
    end
    for (int c = 0; c < 5; c++) begin
      sb_cycle(1'b1, seq, 2'd1, 1'b0, acc);
      if (acc) seq++;
    end
    for (int c = 0; c < 85; c++) begin
      sb_cycle(1'b1, seq, 2'd1, 1'b1, acc);
      if (acc) seq++;
    end
    for (int c = 0; c < 2; c++) sb_cycle(1'b0, 16'h0, 2'd1, 1'b1, acc);

    // Asynchronous reset while holding, then random traffic
    do_reset();
    sb_reset();
    for (int c = 0; c < 4; c++) sb_cycle(1'b1, 16'h8000 + 16'(c), 2'd0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_val", o_val, 1'b0);
    chk("t6_row", o_row, '0);
    chk("t6_size", o_size, 2'd0);
    chk("t6_rdy", o_rdy, 1'b1);
    i_val = 1'b0; i_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_reset();
    for (int c = 0; c < 600; c++) begin
      sb_cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 16'($urandom),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc);
    end
    for (int c = 0; c < 2; c++) sb_cycle(1'b0, 16'h0, 2'd0, 1'b1, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
